// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster bus between the timing generator, painter chain and DAC pins
interface vga_timing_gen_if;
  logic        ce;
  logic [10:0] hst;
  logic [9:0]  vst;
  logic        frame_start;
  logic [2:0]  rgb_i;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic [2:0]  rgb_o;

  modport master (
    input  ce, rgb_i,
    output hst, vst, frame_start, hsync, vsync, video_on, rgb_o
  );

  modport slave (
    output ce, rgb_i,
    input  hst, vst, frame_start, hsync, vsync, video_on, rgb_o
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, delayed sync/blank strobes and blanked RGB output
// Optional macro VGA_TIMING_SYNC_NEG_EN selects active-low hsync/vsync.
module vga_timing_gen #(
  parameter int SCREEN_WIDTH  = 800,
  parameter int SCREEN_HEIGHT = 600,
  parameter int H_FP          = 40,
  parameter int H_SYNC        = 128,
  parameter int H_BP          = 88,
  parameter int V_FP          = 1,
  parameter int V_SYNC        = 4,
  parameter int V_BP          = 23,
  parameter int SYNC_DELAY    = 1
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL = SCREEN_WIDTH + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = SCREEN_HEIGHT + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(SCREEN_WIDTH);
  localparam logic [10:0] HS_FIRST = 11'(SCREEN_WIDTH + H_FP);
  localparam logic [10:0] HS_LAST  = 11'(SCREEN_WIDTH + H_FP + H_SYNC - 1);

  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VIS    = 10'(SCREEN_HEIGHT);
  localparam logic [9:0] VS_FIRST = 10'(SCREEN_HEIGHT + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(SCREEN_HEIGHT + V_FP + V_SYNC - 1);

  logic [10:0] hst;
  logic [9:0]  vst;
  logic        h_last;
  logic        v_last;
  logic        vis;
  logic        hs_raw;
  logic        vs_raw;
  logic        vis_gate;
  logic [2:0]  rgb_q;

  // Each stage holds {vis, hs, vs} in active-high form; polarity is applied only at the output.
  logic [2:0]  pipe [SYNC_DELAY];

  assign h_last = (hst == H_LAST);
  assign v_last = (vst == V_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hst <= '0;
      vst <= '0;
    end else if (bus.ce) begin
      if (h_last) begin
        hst <= '0;
        vst <= v_last ? 10'd0 : vst + 10'd1;
      end else begin
        hst <= hst + 11'd1;
      end
    end
  end

  assign vis    = (hst < H_VIS) && (vst < V_VIS);
  assign hs_raw = (hst >= HS_FIRST) && (hst <= HS_LAST);
  assign vs_raw = (vst >= VS_FIRST) && (vst <= VS_LAST);

  // Shifts every clk, independent of ce, to stay in step with the painter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_DELAY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= {vis, hs_raw, vs_raw};
      for (int i = 1; i < SYNC_DELAY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  // Blanking uses the stage feeding the output register so rgb_o lines up with video_on.
  generate
    if (SYNC_DELAY == 1) begin : g_gate_raw
      assign vis_gate = vis;
    end else begin : g_gate_pipe
      assign vis_gate = pipe[SYNC_DELAY-2][2];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= vis_gate ? bus.rgb_i : 3'b000;
    end
  end

  assign bus.hst         = hst;
  assign bus.vst         = vst;
  assign bus.frame_start = bus.ce && h_last && v_last;
  assign bus.video_on    = pipe[SYNC_DELAY-1][2];
  assign bus.rgb_o       = rgb_q;

`ifdef VGA_TIMING_SYNC_NEG_EN
  assign bus.hsync = ~pipe[SYNC_DELAY-1][1];
  assign bus.vsync = ~pipe[SYNC_DELAY-1][0];
`else
  assign bus.hsync = pipe[SYNC_DELAY-1][1];
  assign bus.vsync = pipe[SYNC_DELAY-1][0];
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench: full-size raster for horizontal timing, small raster for frame timing
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if i0 ();
  vga_timing_gen_if i1 ();

  vga_timing_gen u0 (
    .clk (clk),
    .rst (rst0),
    .bus (i0.master)
  );

  // 16 x 10 raster: hs at hst 10..12, vs at vst 7..8, 8x6 visible, two-stage delay.
  vga_timing_gen #(
    .SCREEN_WIDTH (8),
    .SCREEN_HEIGHT(6),
    .H_FP         (2),
    .H_SYNC       (3),
    .H_BP         (3),
    .V_FP         (1),
    .V_SYNC       (2),
    .V_BP         (1),
    .SYNC_DELAY   (2)
  ) u1 (
    .clk (clk),
    .rst (rst1),
    .bus (i1.master)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic adv0(input int h, input int v, input int budget);
    int n = 0;
    while (!(i0.hst == 11'(h) && i0.vst == 10'(v)) && n < budget) begin
      tick();
      n++;
    end
    chk("adv0_reach", {31'd0, (i0.hst == 11'(h) && i0.vst == 10'(v))}, 32'd1);
  endtask

  task automatic adv1(input int h, input int v, input int budget);
    int n = 0;
    while (!(i1.hst == 11'(h) && i1.vst == 10'(v)) && n < budget) begin
      tick();
      n++;
    end
    chk("adv1_reach", {31'd0, (i1.hst == 11'(h) && i1.vst == 10'(v))}, 32'd1);
  endtask

  initial begin
    int cnt;
    int vs_cnt;
    int vo_cnt;
    int fs_cnt;
    int bad;

    rst0 = 1'b1;
    rst1 = 1'b1;
    i0.ce = 1'b1;
    i1.ce = 1'b1;
    i0.rgb_i = 3'b111;
    i1.rgb_i = 3'b111;
    repeat (3) tick();

    chk("rst_hst", 32'(i0.hst), 32'd0);
    chk("rst_vst", 32'(i0.vst), 32'd0);
    chk("rst_rgb", 32'(i0.rgb_o), 32'd0);
    chk("rst_video", 32'(i0.video_on), 32'd0);
`ifdef VGA_TIMING_SYNC_NEG_EN
    chk("rst_hsync", 32'(i0.hsync), 32'd1);
    chk("rst_vsync", 32'(i0.vsync), 32'd1);
`else
    chk("rst_hsync", 32'(i0.hsync), 32'd0);
    chk("rst_vsync", 32'(i0.vsync), 32'd0);
`endif
    chk("rst_fs", 32'(i0.frame_start), 32'd0);
    chk("rst1_hst", 32'(i1.hst), 32'd0);

    rst0 = 1'b0;
    tick();
    chk("first_hst", 32'(i0.hst), 32'd1);
    chk("first_video", 32'(i0.video_on), 32'd1);
    chk("first_rgb", 32'(i0.rgb_o), 32'd7);
    tick();
    chk("hst_2", 32'(i0.hst), 32'd2);
    tick();
    chk("hst_3", 32'(i0.hst), 32'd3);

    // Asynchronous reset mid-line, checked between clock edges.
    adv0(500, 0, 1000);
    #2;
    rst0 = 1'b1;
    #1;
    chk("arst_hst", 32'(i0.hst), 32'd0);
    chk("arst_vst", 32'(i0.vst), 32'd0);
    chk("arst_rgb", 32'(i0.rgb_o), 32'd0);
    chk("arst_video", 32'(i0.video_on), 32'd0);
`ifdef VGA_TIMING_SYNC_NEG_EN
    chk("arst_hsync", 32'(i0.hsync), 32'd1);
`else
    chk("arst_hsync", 32'(i0.hsync), 32'd0);
`endif
    tick();
    rst0 = 1'b0;
    tick();
    chk("rel_hst_1", 32'(i0.hst), 32'd1);
    tick();
    chk("rel_hst_2", 32'(i0.hst), 32'd2);

    // ce hold
    adv0(100, 0, 1000);
    i0.ce = 1'b0;
    repeat (5) tick();
    chk("hold_hst", 32'(i0.hst), 32'd100);
    chk("hold_vst", 32'(i0.vst), 32'd0);
    chk("hold_video", 32'(i0.video_on), 32'd1);
    i0.ce = 1'b1;
    tick();
    chk("resume_hst", 32'(i0.hst), 32'd101);

    // Visible edge and blanking
    adv0(800, 0, 1000);
    chk("vis_end_video", 32'(i0.video_on), 32'd1);
    chk("vis_end_rgb", 32'(i0.rgb_o), 32'd7);
    tick();
    chk("blank_video", 32'(i0.video_on), 32'd0);
    chk("blank_rgb", 32'(i0.rgb_o), 32'd0);

    // hsync window, one clk behind the counter
    adv0(840, 0, 1000);
`ifdef VGA_TIMING_SYNC_NEG_EN
    chk("hs_before", 32'(i0.hsync), 32'd1);
    cnt = 0;
    tick();
    while (i0.hsync === 1'b0 && cnt < 300) begin
      cnt++;
      tick();
    end
`else
    chk("hs_before", 32'(i0.hsync), 32'd0);
    cnt = 0;
    tick();
    while (i0.hsync === 1'b1 && cnt < 300) begin
      cnt++;
      tick();
    end
`endif
    chk("hs_width", 32'(cnt), 32'd128);
    chk("hs_end_hst", 32'(i0.hst), 32'd969);

    // Line wrap
    adv0(1055, 0, 1000);
    tick();
    chk("wrap_hst", 32'(i0.hst), 32'd0);
    chk("wrap_vst", 32'(i0.vst), 32'd1);

    // Small raster, SYNC_DELAY = 2
    rst1 = 1'b0;
    tick();
    chk("d2_hst1", 32'(i1.hst), 32'd1);
    chk("d2_video1", 32'(i1.video_on), 32'd0);
    chk("d2_rgb1", 32'(i1.rgb_o), 32'd0);
    tick();
    chk("d2_video2", 32'(i1.video_on), 32'd1);
    chk("d2_rgb2", 32'(i1.rgb_o), 32'd7);
    i1.rgb_i = 3'b101;
    tick();
    chk("rgb_latency", 32'(i1.rgb_o), 32'd5);
    i1.rgb_i = 3'b111;

    vs_cnt = 0;
    vo_cnt = 0;
    fs_cnt = 0;
    bad = 0;
    for (int k = 0; k < 320; k++) begin
      tick();
      vs_cnt += (i1.vsync === 1'b`ifdef VGA_TIMING_SYNC_NEG_EN 0 `else 1 `endif) ? 1 : 0;
      vo_cnt += (i1.video_on === 1'b1) ? 1 : 0;
      fs_cnt += (i1.frame_start === 1'b1) ? 1 : 0;
      if (i1.rgb_o !== (i1.video_on ? 3'b111 : 3'b000)) bad++;
    end
    chk("vs_clks_2fr", 32'(vs_cnt), 32'd64);
    chk("video_clks_2fr", 32'(vo_cnt), 32'd96);
    chk("fs_pulses_2fr", 32'(fs_cnt), 32'd2);
    chk("blank_mismatch", 32'(bad), 32'd0);

    adv1(1, 7, 400);
`ifdef VGA_TIMING_SYNC_NEG_EN
    chk("vs_pre", 32'(i1.vsync), 32'd1);
    tick();
    chk("vs_rise", 32'(i1.vsync), 32'd0);
`else
    chk("vs_pre", 32'(i1.vsync), 32'd0);
    tick();
    chk("vs_rise", 32'(i1.vsync), 32'd1);
`endif
    adv1(15, 8, 400);
    chk("fs_not_yet", 32'(i1.frame_start), 32'd0);
    adv1(1, 9, 400);
`ifdef VGA_TIMING_SYNC_NEG_EN
    chk("vs_tail", 32'(i1.vsync), 32'd0);
    tick();
    chk("vs_fall", 32'(i1.vsync), 32'd1);
`else
    chk("vs_tail", 32'(i1.vsync), 32'd1);
    tick();
    chk("vs_fall", 32'(i1.vsync), 32'd0);
`endif
    adv1(15, 9, 400);
    chk("fs_pulse", 32'(i1.frame_start), 32'd1);
    i1.ce = 1'b0;
    #1;
    chk("fs_ce_low", 32'(i1.frame_start), 32'd0);
    i1.ce = 1'b1;
    tick();
    chk("fwrap_hst", 32'(i1.hst), 32'd0);
    chk("fwrap_vst", 32'(i1.vst), 32'd0);
    chk("fs_after", 32'(i1.frame_start), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
